// File: rtl/mem_access_stage_if.sv
// Memory bus between the MEM stage (master) and data memory (slave).
// Request is held stable until the slave returns ack with read data.
interface mem_access_stage_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage: stalls the pipe while a load/store runs on the bus.
// Define MEM_ALIGN_CHECK_EN to trap misaligned word/halfword accesses.
module mem_access_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] EXResultInput,
  input  logic [31:0] RegDataBInput,
  input  logic        MemReadInput,
  input  logic        MemWriteInput,
  input  logic [1:0]  MemReadSelectInput,
  input  logic        MemWriteSelectInput,
  input  logic [5:0]  RegDestInput,
  input  logic        RegWriteInput,
  input  logic        MemToRegInput,
  mem_access_stage_if.master bus,
  output logic [31:0] MemResultOutput,
  output logic [5:0]  RegDestOutput,
  output logic        RegWriteOutput,
  output logic        StallOutput
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        ExcAdelOutput,
  output logic        ExcAdesOutput
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state, state_n;
  logic        access, go;
  logic [1:0]  lo;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic        req_q, we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q, wdata_q, load_q;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ext_v;

  assign lo     = EXResultInput[1:0];
  assign access = MemReadInput | MemWriteInput;

`ifdef MEM_ALIGN_CHECK_EN
  logic mis_ld, mis_st, exc;
  assign mis_st = ~MemWriteSelectInput & (|lo);
  assign mis_ld = ((MemReadSelectInput == 2'b00) & (|lo))
                | ((MemReadSelectInput == 2'b11) & lo[0]);
  assign ExcAdesOutput = (state == IDLE) & MemWriteInput & mis_st;
  assign ExcAdelOutput = (state == IDLE) & MemReadInput
                       & ~MemWriteInput & mis_ld;
  assign exc = ExcAdelOutput | ExcAdesOutput;
  assign go  = access & ~exc;
  assign RegWriteOutput = RegWriteInput & ~StallOutput & ~exc;
`else
  assign go  = access;
  assign RegWriteOutput = RegWriteInput & ~StallOutput;
`endif

  assign RegDestOutput = RegDestInput;

  // A simultaneous read+write request is issued as a write.
  always_comb begin
    be_n    = 4'hF;
    wdata_n = RegDataBInput;
    if (MemWriteInput) begin
      if (MemWriteSelectInput) begin
        be_n    = 4'b0001 << lo;
        wdata_n = {4{RegDataBInput[7:0]}};
      end
    end else begin
      unique case (MemReadSelectInput)
        2'b01, 2'b10: be_n = 4'b0001 << lo;
        2'b11:        be_n = lo[1] ? 4'b1100 : 4'b0011;
        default:      be_n = 4'hF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n     = state;
    StallOutput = 1'b0;
    unique case (state)
      IDLE: begin
        if (go) begin
          StallOutput = 1'b1;
          state_n     = REQ;
        end
      end
      REQ: begin
        StallOutput = 1'b1;
        if (bus.bus_ack) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      load_q  <= 32'h0;
    end else if (state == IDLE && go) begin
      req_q   <= 1'b1;
      we_q    <= MemWriteInput;
      be_q    <= be_n;
      addr_q  <= {EXResultInput[31:2], 2'b00};
      wdata_q <= wdata_n;
    end else if (state == REQ && bus.bus_ack) begin
      req_q  <= 1'b0;
      load_q <= bus.bus_rdata;
    end
  end

  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;

  // Lane select uses the live address; EX/MEM is frozen until DONE.
  always_comb begin
    byte_v = load_q[{lo, 3'b000} +: 8];
    half_v = lo[1] ? load_q[31:16] : load_q[15:0];
    unique case (MemReadSelectInput)
      2'b01:   ext_v = {{24{byte_v[7]}}, byte_v};
      2'b10:   ext_v = {24'h0, byte_v};
      2'b11:   ext_v = {{16{half_v[15]}}, half_v};
      default: ext_v = load_q;
    endcase
  end

  assign MemResultOutput = MemToRegInput ? ext_v : EXResultInput;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage.
// Build with +define+MEM_ALIGN_CHECK_EN to exercise alignment traps.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] EXResultInput, RegDataBInput;
  logic        MemReadInput, MemWriteInput;
  logic [1:0]  MemReadSelectInput;
  logic        MemWriteSelectInput;
  logic [5:0]  RegDestInput;
  logic        RegWriteInput, MemToRegInput;
  logic [31:0] MemResultOutput;
  logic [5:0]  RegDestOutput;
  logic        RegWriteOutput, StallOutput;
`ifdef MEM_ALIGN_CHECK_EN
  logic        ExcAdelOutput, ExcAdesOutput;
`endif

  mem_access_stage_if bus();

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk                 (clk),
    .rst                 (rst),
    .EXResultInput       (EXResultInput),
    .RegDataBInput       (RegDataBInput),
    .MemReadInput        (MemReadInput),
    .MemWriteInput       (MemWriteInput),
    .MemReadSelectInput  (MemReadSelectInput),
    .MemWriteSelectInput (MemWriteSelectInput),
    .RegDestInput        (RegDestInput),
    .RegWriteInput       (RegWriteInput),
    .MemToRegInput       (MemToRegInput),
    .bus                 (bus.master),
    .MemResultOutput     (MemResultOutput),
    .RegDestOutput       (RegDestOutput),
    .RegWriteOutput      (RegWriteOutput),
    .StallOutput         (StallOutput)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .ExcAdelOutput       (ExcAdelOutput),
    .ExcAdesOutput       (ExcAdesOutput)
`endif
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] res;
    int          stalls;
  } exp_t;

  exp_t sb[$];

  function automatic logic [3:0] model_be(
    input logic wr, input logic wsel,
    input logic [1:0] rsel, input logic [31:0] a);
    if (wr) return wsel ? (4'b0001 << a[1:0]) : 4'b1111;
    case (rsel)
      2'b00:   return 4'b1111;
      2'b11:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b0001 << a[1:0];
    endcase
  endfunction

  function automatic logic [31:0] model_result(
    input logic mtr, input logic [1:0] rsel,
    input logic [31:0] a, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    if (!mtr) return a;
    case (a[1:0])
      2'd0: b = d[7:0];
      2'd1: b = d[15:8];
      2'd2: b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (rsel)
      2'b00: return d;
      2'b01: return b[7] ? {24'hFFFFFF, b} : {24'h0, b};
      2'b10: return {24'h0, b};
      default: return h[15] ? {16'hFFFF, h} : {16'h0, h};
    endcase
  endfunction

  task automatic set_idle();
    MemReadInput   = 1'b0;
    MemWriteInput  = 1'b0;
    MemToRegInput  = 1'b0;
    bus.bus_ack    = 1'b0;
  endtask

  // One access with ack raised in REQ cycle d; stimulus and
  // expectations enter the scoreboard together.
  task automatic run_access(
    input logic rd, input logic wr,
    input logic [1:0] rsel, input logic wsel,
    input logic mtr, input logic [31:0] a,
    input logic [31:0] bd, input logic [31:0] rdata,
    input int d, input string name);
    exp_t e;
    int st;
    e.addr   = {a[31:2], 2'b00};
    e.we     = wr;
    e.be     = model_be(wr, wsel, rsel, a);
    e.wdata  = (wr && wsel) ? {4{bd[7:0]}} : bd;
    e.res    = model_result(mtr, rsel, a, rdata);
    e.stalls = 1 + d;
    sb.push_back(e);
    @(posedge clk); #1;
    EXResultInput       = a;
    RegDataBInput       = bd;
    MemReadInput        = rd;
    MemWriteInput       = wr;
    MemReadSelectInput  = rsel;
    MemWriteSelectInput = wsel;
    MemToRegInput       = mtr;
    RegDestInput        = 6'h15;
    RegWriteInput       = 1'b1;
    bus.bus_rdata       = rdata;
    bus.bus_ack         = 1'b0;
    st = 0;
    @(negedge clk);
    if (StallOutput === 1'b1) st++;
    checks++;
    if (StallOutput !== 1'b1 || bus.bus_req !== 1'b0 ||
        RegWriteOutput !== 1'b0) begin
      failures++;
      $display("FAIL %s idle: stall=%b req=%b rw=%b required 1 0 0",
               name, StallOutput, bus.bus_req, RegWriteOutput);
    end
    for (int k = 1; k <= d; k++) begin
      @(negedge clk);
      if (StallOutput === 1'b1) st++;
      checks++;
      if (bus.bus_req !== 1'b1 || bus.bus_addr !== sb[0].addr ||
          bus.bus_we !== sb[0].we || bus.bus_be !== sb[0].be) begin
        failures++;
        $display("FAIL %s req%0d: req=%b addr=%h we=%b be=%b required 1 %h %b %b",
                 name, k, bus.bus_req, bus.bus_addr, bus.bus_we,
                 bus.bus_be, sb[0].addr, sb[0].we, sb[0].be);
      end
      if (wr) begin
        checks++;
        if (bus.bus_wdata !== sb[0].wdata) begin
          failures++;
          $display("FAIL %s wdata: got %h required %h",
                   name, bus.bus_wdata, sb[0].wdata);
        end
      end
      if (k == d) bus.bus_ack = 1'b1;
    end
    @(posedge clk); #1;
    bus.bus_ack = 1'b0;
    @(negedge clk);
    if (StallOutput === 1'b1) st++;
    checks++;
    if (StallOutput !== 1'b0 || bus.bus_req !== 1'b0 ||
        RegWriteOutput !== 1'b1 || RegDestOutput !== 6'h15) begin
      failures++;
      $display("FAIL %s done: stall=%b req=%b rw=%b rd=%h required 0 0 1 15",
               name, StallOutput, bus.bus_req, RegWriteOutput, RegDestOutput);
    end
    checks++;
    if (MemResultOutput !== sb[0].res || st != sb[0].stalls) begin
      failures++;
      $display("FAIL %s result: got %h stalls=%0d required %h stalls=%0d",
               name, MemResultOutput, st, sb[0].res, sb[0].stalls);
    end
    void'(sb.pop_front());
  endtask

  task automatic test_reset();
    rst                 = 1'b0;
    EXResultInput       = 32'h0;
    RegDataBInput       = 32'h0;
    MemReadSelectInput  = 2'b00;
    MemWriteSelectInput = 1'b0;
    RegDestInput        = 6'h0;
    RegWriteInput       = 1'b1;
    bus.bus_rdata       = 32'h0;
    set_idle();
    #13;
    checks++;
    if (bus.bus_req !== 1'b0 || bus.bus_we !== 1'b0 ||
        bus.bus_be !== 4'h0 || bus.bus_addr !== 32'h0 ||
        bus.bus_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_bus: req=%b we=%b be=%b addr=%h wd=%h required all 0",
               bus.bus_req, bus.bus_we, bus.bus_be, bus.bus_addr,
               bus.bus_wdata);
    end
    checks++;
    if (StallOutput !== 1'b0 || RegWriteOutput !== 1'b1) begin
      failures++;
      $display("FAIL reset_ctl: stall=%b rw=%b required 0 1",
               StallOutput, RegWriteOutput);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_stray_ack();
    @(posedge clk); #1;
    MemToRegInput      = 1'b1;
    MemReadSelectInput = 2'b00;
    bus.bus_rdata      = 32'hCAFEF00D;
    bus.bus_ack        = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (MemResultOutput !== 32'h0 || bus.bus_req !== 1'b0 ||
          StallOutput !== 1'b0) begin
        failures++;
        $display("FAIL stray_ack: res=%h req=%b stall=%b required 0 0 0",
                 MemResultOutput, bus.bus_req, StallOutput);
      end
    end
    @(posedge clk); #1;
    set_idle();
  endtask

  task automatic test_passthrough();
    @(posedge clk); #1;
    set_idle();
    EXResultInput = 32'h1234;
    RegDestInput  = 6'h2A;
    RegWriteInput = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (StallOutput !== 1'b0 || MemResultOutput !== 32'h1234 ||
          RegWriteOutput !== 1'b1 || RegDestOutput !== 6'h2A ||
          bus.bus_req !== 1'b0) begin
        failures++;
        $display("FAIL passthrough: stall=%b res=%h rw=%b rd=%h req=%b required 0 1234 1 2a 0",
                 StallOutput, MemResultOutput, RegWriteOutput,
                 RegDestOutput, bus.bus_req);
      end
    end
  endtask

  task automatic test_loads();
    run_access(1, 0, 2'b00, 0, 1, 32'h100, 32'h0, 32'hDEADBEEF, 3, "ld_word");
    run_access(1, 0, 2'b01, 0, 1, 32'h103, 32'h0, 32'h80112233, 1, "ld_sbyte");
    run_access(1, 0, 2'b10, 0, 1, 32'h103, 32'h0, 32'h80112233, 2, "ld_ubyte");
    run_access(1, 0, 2'b01, 0, 1, 32'h101, 32'h0, 32'h80112233, 1, "ld_sbyte1");
    run_access(1, 0, 2'b11, 0, 1, 32'h102, 32'h0, 32'h80017FFF, 1, "ld_half_hi");
    run_access(1, 0, 2'b11, 0, 1, 32'h100, 32'h0, 32'h80017FFF, 2, "ld_half_lo");
    @(posedge clk); #1;
    set_idle();
  endtask

  task automatic test_stores();
    run_access(0, 1, 2'b00, 1, 0, 32'h202, 32'h000000A5, 32'h0, 1, "st_byte");
    run_access(0, 1, 2'b00, 0, 0, 32'h400, 32'h12345678, 32'h0, 2, "st_word");
    run_access(1, 1, 2'b00, 1, 0, 32'h001, 32'h0000003C, 32'h0, 1, "rd_wr_both");
    @(posedge clk); #1;
    set_idle();
  endtask

  task automatic test_back_to_back();
    run_access(1, 0, 2'b00, 0, 1, 32'h500, 32'h0, 32'h11223344, 1, "b2b_ld");
    run_access(0, 1, 2'b00, 0, 0, 32'h504, 32'h55667788, 32'h0, 1, "b2b_st");
    run_access(1, 0, 2'b10, 0, 1, 32'h506, 32'h0, 32'h00AB0000, 1, "b2b_ldb");
    @(posedge clk); #1;
    set_idle();
  endtask

  task automatic test_reset_mid_req();
    @(posedge clk); #1;
    EXResultInput      = 32'h300;
    MemReadInput       = 1'b1;
    MemReadSelectInput = 2'b00;
    MemToRegInput      = 1'b1;
    bus.bus_rdata      = 32'hFFFFFFFF;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.bus_req !== 1'b1) begin
      failures++;
      $display("FAIL mid_req_pre: req=%b required 1", bus.bus_req);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.bus_req !== 1'b0 || bus.bus_addr !== 32'h0 ||
        bus.bus_be !== 4'h0) begin
      failures++;
      $display("FAIL mid_req_rst: req=%b addr=%h be=%b required 0 0 0",
               bus.bus_req, bus.bus_addr, bus.bus_be);
    end
    MemReadInput = 1'b0;
    @(posedge clk); #1;
    rst         = 1'b1;
    bus.bus_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.bus_req !== 1'b0 || StallOutput !== 1'b0 ||
          MemResultOutput !== 32'h0 || RegWriteOutput !== 1'b1) begin
        failures++;
        $display("FAIL mid_req_after: req=%b stall=%b res=%h rw=%b required 0 0 0 1",
                 bus.bus_req, StallOutput, MemResultOutput, RegWriteOutput);
      end
    end
    @(posedge clk); #1;
    set_idle();
  endtask

`ifdef MEM_ALIGN_CHECK_EN
  task automatic test_align();
    @(posedge clk); #1;
    EXResultInput      = 32'h101;
    MemReadInput       = 1'b1;
    MemReadSelectInput = 2'b00;
    RegWriteInput      = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (ExcAdelOutput !== 1'b1 || ExcAdesOutput !== 1'b0 ||
          StallOutput !== 1'b0 || bus.bus_req !== 1'b0 ||
          RegWriteOutput !== 1'b0) begin
        failures++;
        $display("FAIL align_ld: adel=%b ades=%b stall=%b req=%b rw=%b required 1 0 0 0 0",
                 ExcAdelOutput, ExcAdesOutput, StallOutput,
                 bus.bus_req, RegWriteOutput);
      end
    end
    @(posedge clk); #1;
    MemReadInput        = 1'b0;
    MemWriteInput       = 1'b1;
    MemWriteSelectInput = 1'b0;
    EXResultInput       = 32'h102;
    @(negedge clk);
    checks++;
    if (ExcAdesOutput !== 1'b1 || ExcAdelOutput !== 1'b0 ||
        bus.bus_req !== 1'b0) begin
      failures++;
      $display("FAIL align_st: ades=%b adel=%b req=%b required 1 0 0",
               ExcAdesOutput, ExcAdelOutput, bus.bus_req);
    end
    @(posedge clk); #1;
    set_idle();
  endtask
`else
  task automatic test_align();
    run_access(1, 0, 2'b00, 0, 1, 32'h101, 32'h0, 32'h0BADF00D, 1, "unaligned_word");
    run_access(1, 0, 2'b11, 0, 1, 32'h103, 32'h0, 32'h9000_0001, 1, "unaligned_half");
    @(posedge clk); #1;
    set_idle();
  endtask
`endif

  initial begin
    test_reset();
    test_stray_ack();
    test_passthrough();
    test_loads();
    test_stores();
    test_back_to_back();
    test_reset_mid_req();
    test_align();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
